// File: rtl/bonsai_pkg.sv
// Shared constants and helpers for the merger-tree leaf feeders.
package bonsai_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LINE_WIDTH = 512;
  localparam int WORDS_PER_LINE = DEF_LINE_WIDTH / DEF_DATA_WIDTH;

  // Width needed to index 'value' distinct items; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/leaf_line_unpacker_if.sv
// Bus between the line arbiter / read-data path / leaf FIFO and one leaf unpacker.
interface leaf_line_unpacker_if
  import bonsai_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
);
  // Handshakes: o_req is a level, i_grant a one-cycle pulse counted only while
  // o_req=1; a line transfers on any cycle with i_line_valid & o_line_ready;
  // a record transfers on any cycle with o_enq, which is never high with i_fifo_full.
  logic                  o_req;
  logic                  i_grant;
  logic [LINE_WIDTH-1:0] i_line;
  logic                  i_line_valid;
  logic                  o_line_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_enq;
  logic                  i_fifo_full;
  logic                  o_done;
  logic                  o_err;
  logic [7:0]            dbg_occupancy;
  logic [7:0]            dbg_word_ptr;
  logic [15:0]           dbg_words_emitted;

  modport master (
    input  o_req, o_line_ready, o_data, o_enq, o_done, o_err,
           dbg_occupancy, dbg_word_ptr, dbg_words_emitted,
    output i_grant, i_line, i_line_valid, i_fifo_full
  );

  modport slave (
    output o_req, o_line_ready, o_data, o_enq, o_done, o_err,
           dbg_occupancy, dbg_word_ptr, dbg_words_emitted,
    input  i_grant, i_line, i_line_valid, i_fifo_full
  );
endinterface

// File: rtl/leaf_line_buffer.sv
// Small register FIFO holding whole memory lines for one leaf.
module leaf_line_buffer
  import bonsai_pkg::*;
#(
  parameter int  LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int  DEPTH      = 2,
  localparam int PTR_W      = clog2(DEPTH),
  localparam int OCC_W      = clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [LINE_WIDTH-1:0] i_line,
  input  logic                  i_pop,
  output logic [LINE_WIDTH-1:0] o_head,
  output logic [OCC_W-1:0]      o_occupancy,
  output logic                  o_empty,
  output logic                  o_full
);

  logic [LINE_WIDTH-1:0] mem_q [DEPTH];
  logic [LINE_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full      = (int'(count_q) == DEPTH);
  assign o_empty     = (count_q == '0);
  assign o_occupancy = count_q;
  assign o_head      = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot the push needs.
    do_push  = i_push & (~o_full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_line;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/leaf_line_unpacker.sv
// Requests lines under credit control and streams their records, one per cycle,
// into a merger-tree leaf FIFO until the leaf's sequence is exhausted.
module leaf_line_unpacker
  import bonsai_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
  parameter int SEQ_WORDS      = 404,
  parameter int LINE_BUF_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  leaf_line_unpacker_if.slave  bus
);

  localparam int WPL         = LINE_WIDTH / DATA_WIDTH;
  localparam int LINES_TOTAL = (SEQ_WORDS + WPL - 1) / WPL;
  localparam int OCC_W       = clog2(LINE_BUF_DEPTH + 1);
  localparam int PTR_W       = clog2(WPL);
  localparam int LREQ_W      = clog2(LINES_TOTAL + 1);
  localparam int WCNT_W      = clog2(SEQ_WORDS + 1);

  logic [OCC_W-1:0]      outstanding_q, outstanding_d;
  logic [LREQ_W-1:0]     lines_req_q, lines_req_d;
  logic [PTR_W-1:0]      word_ptr_q, word_ptr_d;
  logic [WCNT_W-1:0]     words_emitted_q, words_emitted_d;
  logic [DATA_WIDTH-1:0] last_data_q, last_data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [LINE_WIDTH-1:0] head_line;
  logic [OCC_W-1:0]      occupancy;
  logic                  buf_empty, buf_full;
  logic                  push, pop, emit, accept, grant_ok;
  logic                  req, line_ready, last_record, end_of_line;
  logic [DATA_WIDTH-1:0] head_word;

  leaf_line_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .DEPTH      (LINE_BUF_DEPTH)
  ) u_buf (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_line      (bus.i_line),
    .i_pop       (pop),
    .o_head      (head_line),
    .o_occupancy (occupancy),
    .o_empty     (buf_empty),
    .o_full      (buf_full)
  );

  always_comb begin
    // Handshake outputs are forced low for as long as reset is held.
    req         = i_rst_n
                & ((int'(outstanding_q) + int'(occupancy)) < LINE_BUF_DEPTH)
                & (int'(lines_req_q) < LINES_TOTAL);
    line_ready  = i_rst_n & ~buf_full;
    accept      = bus.i_line_valid & line_ready;
    push        = accept & (outstanding_q != '0);
    grant_ok    = bus.i_grant & req;
    head_word   = head_line[int'(word_ptr_q) * DATA_WIDTH +: DATA_WIDTH];
    emit        = ~buf_empty & ~bus.i_fifo_full & ~done_q;
    last_record = (int'(words_emitted_q) == SEQ_WORDS - 1);
    end_of_line = (int'(word_ptr_q) == WPL - 1);
    // The final record pops a partial last line, discarding its unused tail.
    pop         = emit & (end_of_line | last_record);

    outstanding_d   = outstanding_q + OCC_W'(grant_ok) - OCC_W'(push);
    lines_req_d     = lines_req_q + LREQ_W'(grant_ok);
    err_d           = err_q | (accept & (outstanding_q == '0));
    word_ptr_d      = word_ptr_q;
    words_emitted_d = words_emitted_q;
    last_data_d     = last_data_q;
    done_d          = done_q;
    if (emit) begin
      last_data_d     = head_word;
      word_ptr_d      = pop ? '0 : word_ptr_q + PTR_W'(1);
      words_emitted_d = words_emitted_q + WCNT_W'(1);
      done_d          = done_q | last_record;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outstanding_q   <= '0;
      lines_req_q     <= '0;
      word_ptr_q      <= '0;
      words_emitted_q <= '0;
      last_data_q     <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      outstanding_q   <= outstanding_d;
      lines_req_q     <= lines_req_d;
      word_ptr_q      <= word_ptr_d;
      words_emitted_q <= words_emitted_d;
      last_data_q     <= last_data_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign bus.o_req             = req;
  assign bus.o_line_ready      = line_ready;
  assign bus.o_data            = buf_empty ? last_data_q : head_word;
  assign bus.o_enq             = emit;
  assign bus.o_done            = done_q;
  assign bus.o_err             = err_q;
  assign bus.dbg_occupancy     = 8'(occupancy);
  assign bus.dbg_word_ptr      = 8'(word_ptr_q);
  assign bus.dbg_words_emitted = 16'(words_emitted_q);

endmodule

// File: tb/tb_leaf_line_unpacker.sv
// Bench for leaf_line_unpacker: directed scenarios plus randomized streams
// checked against a record-order model built from the line contents.
module tb_leaf_line_unpacker;

  localparam int DW    = bonsai_pkg::DEF_DATA_WIDTH;
  localparam int LW    = bonsai_pkg::DEF_LINE_WIDTH;
  localparam int WPL   = bonsai_pkg::WORDS_PER_LINE;
  localparam int SEQ   = 404;
  localparam int DEPTH = 2;
  localparam int LINES = (SEQ + WPL - 1) / WPL;

  logic i_clk = 1'b0;
  logic i_rst_n;

  leaf_line_unpacker_if #(.DATA_WIDTH(DW), .LINE_WIDTH(LW)) bus ();

  leaf_line_unpacker #(
    .DATA_WIDTH     (DW),
    .LINE_WIDTH     (LW),
    .SEQ_WORDS      (SEQ),
    .LINE_BUF_DEPTH (DEPTH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] line_mem [LINES][WPL];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int grants_honoured, lines_accepted, done_cyc, last_enq_cyc, enq_after_done;
  bit timed_out;

  task automatic drive_idle();
    bus.i_grant      = 1'b0;
    bus.i_line       = '0;
    bus.i_line_valid = 1'b0;
    bus.i_fifo_full  = 1'b0;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  task automatic fill_lines(input bit use_index);
    for (int l = 0; l < LINES; l++)
      for (int k = 0; k < WPL; k++)
        line_mem[l][k] = use_index ? DW'(l * WPL + k) : DW'($urandom);
  endtask

  // The leaf sees the first SEQ records in line order; the rest never appear.
  task automatic build_exp();
    exp_q.delete();
    for (int g = 0; g < SEQ; g++) exp_q.push_back(line_mem[g / WPL][g % WPL]);
  endtask

  function automatic logic [LW-1:0] pack_line(input int l);
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < WPL; k++) v[k*DW +: DW] = line_mem[l][k];
    return v;
  endfunction

  // ---------------- driver: arbiter + read-data path + leaf FIFO ----------------
  task automatic run_stream(input bit rnd, input int stop_after);
    int cyc, last_due, settle, due, lat;
    int due_q[$];
    bit grant_next;
    got_q.delete();
    grants_honoured = 0; lines_accepted = 0; done_cyc = -1; last_enq_cyc = -1;
    enq_after_done = 0; timed_out = 1'b0;
    cyc = 0; last_due = 0; settle = 0; grant_next = 1'b0;
    forever begin
      @(negedge i_clk);
      bus.i_grant     = grant_next;
      bus.i_fifo_full = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc && lines_accepted < LINES) begin
        bus.i_line_valid = 1'b1;
        bus.i_line       = pack_line(lines_accepted);
      end else begin
        bus.i_line_valid = 1'b0;
        bus.i_line       = '0;
      end
      #1;
      if (bus.o_done && done_cyc < 0) done_cyc = cyc;
      if (bus.o_enq) begin
        if (done_cyc >= 0) enq_after_done++;
        got_q.push_back(bus.o_data);
        if (got_q.size() == SEQ) last_enq_cyc = cyc;
      end
      if (bus.i_grant && bus.o_req) begin
        grants_honoured++;
        lat = rnd ? int'($urandom_range(1, 20)) : 3;
        due = (cyc + lat > last_due) ? cyc + lat : last_due;
        due_q.push_back(due);
        last_due = due;
      end
      if (bus.i_line_valid && bus.o_line_ready) begin
        lines_accepted++;
        void'(due_q.pop_front());
      end
      grant_next = bus.o_req && (!rnd || $urandom_range(0, 2) != 0);
      cyc++;
      if (stop_after > 0 && got_q.size() >= stop_after) break;
      if (done_cyc >= 0) begin
        settle++;
        if (settle > 20) break;
      end
      if (cyc > 6000) begin
        timed_out = 1'b1;
        break;
      end
    end
    drive_idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    n_checks++;
    if ({bus.o_req, bus.o_line_ready, bus.o_enq, bus.o_done, bus.o_err} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000",
               {bus.o_req, bus.o_line_ready, bus.o_enq, bus.o_done, bus.o_err});
    else n_pass++;
    n_checks++;
    if (bus.o_data !== '0) $display("FAIL reset_data: got %h want 0", bus.o_data);
    else n_pass++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_req, bus.o_line_ready, bus.dbg_occupancy} !== {2'b11, 8'd0})
      $display("FAIL reset_release: req=%b ready=%b occ=%0d want 1 1 0",
               bus.o_req, bus.o_line_ready, bus.dbg_occupancy);
    else n_pass++;
  endtask

  task automatic check_stream(input string name);
    n_checks++;
    if (timed_out) $display("FAIL %s_timeout: no o_done within cycle budget", name);
    else n_pass++;
    n_checks++;
    if (got_q.size() != SEQ) $display("FAIL %s_count: got %0d records want %0d", name, got_q.size(), SEQ);
    else n_pass++;
    for (int i = 0; i < SEQ && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL %s_rec[%0d]: got %h want %h", name, i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (grants_honoured != LINES || lines_accepted != LINES)
      $display("FAIL %s_lines: grants %0d accepted %0d want %0d", name, grants_honoured, lines_accepted, LINES);
    else n_pass++;
    n_checks++;
    if (done_cyc != last_enq_cyc + 1 || last_enq_cyc < 0)
      $display("FAIL %s_done_time: done at %0d want %0d", name, done_cyc, last_enq_cyc + 1);
    else n_pass++;
    n_checks++;
    if (enq_after_done != 0) $display("FAIL %s_enq_after_done: got %0d want 0", name, enq_after_done);
    else n_pass++;
    n_checks++;
    if ({bus.o_req, bus.o_done} !== 2'b01)
      $display("FAIL %s_final: req=%b done=%b want 0 1", name, bus.o_req, bus.o_done);
    else n_pass++;
  endtask

  task automatic test_nominal();
    fill_lines(1'b1);
    build_exp();
    apply_reset();
    run_stream(1'b0, 0);
    check_stream("nominal");
  endtask

  task automatic test_backpressure();
    fill_lines(1'b0);
    apply_reset();
    @(negedge i_clk);
    bus.i_grant = 1'b1;
    @(negedge i_clk);
    bus.i_grant      = 1'b0;
    bus.i_line_valid = 1'b1;
    bus.i_line       = pack_line(0);
    for (int i = 0; i < 7; i++) begin
      @(negedge i_clk);
      bus.i_line_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.o_enq, bus.o_data} !== {1'b1, line_mem[0][i]})
        $display("FAIL bp_pre[%0d]: enq=%b data=%h want 1 %h", i, bus.o_enq, bus.o_data, line_mem[0][i]);
      else n_pass++;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      bus.i_fifo_full = 1'b1;
      #1;
      n_checks++;
      if ({bus.o_enq, bus.dbg_word_ptr} !== {1'b0, 8'd7})
        $display("FAIL bp_hold[%0d]: enq=%b ptr=%0d want 0 7", c, bus.o_enq, bus.dbg_word_ptr);
      else n_pass++;
    end
    for (int i = 7; i < WPL; i++) begin
      @(negedge i_clk);
      bus.i_fifo_full = 1'b0;
      #1;
      n_checks++;
      if ({bus.o_enq, bus.o_data} !== {1'b1, line_mem[0][i]})
        $display("FAIL bp_post[%0d]: enq=%b data=%h want 1 %h", i, bus.o_enq, bus.o_data, line_mem[0][i]);
      else n_pass++;
    end
  endtask

  task automatic test_credit_limit();
    fill_lines(1'b0);
    apply_reset();
    for (int g = 0; g < 2; g++) begin
      @(negedge i_clk);
      bus.i_grant = 1'b1;
      #1;
      n_checks++;
      if (bus.o_req !== 1'b1) $display("FAIL credit_grant[%0d]: req=%b want 1", g, bus.o_req);
      else n_pass++;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      bus.i_grant = 1'b0;
      #1;
      n_checks++;
      if (bus.o_req !== 1'b0) $display("FAIL credit_block[%0d]: req=%b want 0", c, bus.o_req);
      else n_pass++;
    end
    @(negedge i_clk);
    bus.i_line_valid = 1'b1;
    bus.i_line       = pack_line(0);
    // A delivered line still holds its slot until fully emitted.
    for (int i = 0; i < WPL; i++) begin
      @(negedge i_clk);
      bus.i_line_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.o_req, bus.o_enq, bus.o_data} !== {2'b01, line_mem[0][i]})
        $display("FAIL credit_drain[%0d]: req=%b enq=%b data=%h want 0 1 %h",
                 i, bus.o_req, bus.o_enq, bus.o_data, line_mem[0][i]);
      else n_pass++;
    end
    @(negedge i_clk);
    #1;
    n_checks++;
    if ({bus.o_req, bus.dbg_occupancy} !== {1'b1, 8'd0})
      $display("FAIL credit_return: req=%b occ=%0d want 1 0", bus.o_req, bus.dbg_occupancy);
    else n_pass++;
  endtask

  task automatic test_unsolicited();
    fill_lines(1'b0);
    apply_reset();
    @(negedge i_clk);
    bus.i_line_valid = 1'b1;
    bus.i_line       = pack_line(2);
    #1;
    n_checks++;
    if ({bus.o_line_ready, bus.o_err} !== 2'b10)
      $display("FAIL unsol_before: ready=%b err=%b want 1 0", bus.o_line_ready, bus.o_err);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      bus.i_line_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.o_err, bus.o_enq, bus.dbg_occupancy} !== {2'b10, 8'd0})
        $display("FAIL unsol_after[%0d]: err=%b enq=%b occ=%0d want 1 0 0",
                 c, bus.o_err, bus.o_enq, bus.dbg_occupancy);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    fill_lines(1'b0);
    apply_reset();
    for (int g = 0; g < 2; g++) begin
      @(negedge i_clk);
      bus.i_grant = 1'b1;
    end
    @(negedge i_clk);
    bus.i_grant      = 1'b0;
    bus.i_line_valid = 1'b1;
    bus.i_line       = pack_line(0);
    for (int i = 0; i < WPL - 1; i++) begin
      @(negedge i_clk);
      bus.i_line_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.o_enq, bus.o_data} !== {1'b1, line_mem[0][i]})
        $display("FAIL b2b_l0[%0d]: enq=%b data=%h want 1 %h", i, bus.o_enq, bus.o_data, line_mem[0][i]);
      else n_pass++;
    end
    @(negedge i_clk);
    bus.i_line_valid = 1'b1;
    bus.i_line       = pack_line(1);
    #1;
    n_checks++;
    if ({bus.o_enq, bus.o_line_ready, bus.dbg_occupancy, bus.o_data} !== {2'b11, 8'd1, line_mem[0][WPL-1]})
      $display("FAIL b2b_handoff: enq=%b ready=%b occ=%0d data=%h want 1 1 1 %h",
               bus.o_enq, bus.o_line_ready, bus.dbg_occupancy, bus.o_data, line_mem[0][WPL-1]);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      bus.i_line_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.o_enq, bus.dbg_occupancy, bus.o_data} !== {1'b1, 8'd1, line_mem[1][i]})
        $display("FAIL b2b_l1[%0d]: enq=%b occ=%0d data=%h want 1 1 %h",
                 i, bus.o_enq, bus.dbg_occupancy, bus.o_data, line_mem[1][i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_line();
    fill_lines(1'b1);
    build_exp();
    apply_reset();
    run_stream(1'b0, 3 * WPL + 9);
    @(negedge i_clk);
    #1;
    n_checks++;
    if ({bus.dbg_word_ptr, bus.dbg_words_emitted} !== {8'd9, 16'(3 * WPL + 9)})
      $display("FAIL midrst_pos: ptr=%0d emitted=%0d want 9 %0d",
               bus.dbg_word_ptr, bus.dbg_words_emitted, 3 * WPL + 9);
    else n_pass++;
    i_rst_n = 1'b0;
    drive_idle();
    #1;
    n_checks++;
    if ({bus.o_req, bus.o_line_ready, bus.o_enq, bus.o_done, bus.o_err, bus.o_data,
         bus.dbg_occupancy, bus.dbg_words_emitted} !== '0)
      $display("FAIL midrst_clear: req=%b ready=%b enq=%b done=%b err=%b data=%h occ=%0d emitted=%0d want all 0",
               bus.o_req, bus.o_line_ready, bus.o_enq, bus.o_done, bus.o_err, bus.o_data,
               bus.dbg_occupancy, bus.dbg_words_emitted);
    else n_pass++;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_req, bus.dbg_words_emitted} !== {1'b1, 16'd0})
      $display("FAIL midrst_release: req=%b emitted=%0d want 1 0", bus.o_req, bus.dbg_words_emitted);
    else n_pass++;
    run_stream(1'b0, 0);
    check_stream("midrst_restart");
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      fill_lines(1'b0);
      build_exp();
      apply_reset();
      run_stream(1'b1, 0);
      check_stream($sformatf("random%0d", r));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_credit_limit();
    test_unsolicited();
    test_back_to_back();
    test_reset_mid_line();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
